btn_event_ctrl: RTL
===================

Name: btn_event_ctrl

Overview:
- Sits downstream of one debounce instance per push-button, on their st_o outputs.
- Classifies each button's activity into press, release, long-press and auto-repeat events.
- Shares one event output channel among all buttons through a round-robin arbiter with a valid/ready handshake.
- Consumed by the UI/command logic, which pops one event per accepted cycle.

Parameters:
- N_BTN, 4, number of buttons, 2..16.
- TICK_DIV, 12000, clk cycles per time tick (1 ms at 12 MHz), >=2.
- LONG_T, 500, ticks held before a LONG event, >=2.
- REPEAT_T, 100, ticks between REPEAT events while held past LONG, >=2.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- btn_st, in, N_BTN: debounced button levels, synchronous to clk, 1 = pressed.
- ev_valid, out, 1: event available.
- ev_ready, in, 1: consumer accepts the event; transfer when ev_valid && ev_ready.
- ev_btn, out, clog2(N_BTN): button index of the event.
- ev_code, out, 2: 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
- ev_ovf, out, 1: one-cycle pulse when a pending event was overwritten.

Behaviour:
- Reset (async assert, sync release) clears everything to 0:
  - prescaler, tick, all btn_prev, FSMs to IDLE, hold counters, pending flags and codes
  - RR pointer
  - ev_valid, ev_btn, ev_code, ev_ovf
- Reset while a button is held: after release, btn_prev=0 and btn_st=1, so a PRESS is emitted. Events pending at reset are discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when the count equals TICK_DIV-1.
  - Shared by all buttons.
- Per-button FSM, registered, btn_prev <= btn_st every cycle:
  - IDLE: rise (btn_st && !btn_prev) -> emit PRESS, hold_cnt <= 0, go HELD.
  - HELD: on tick hold_cnt++. When tick && hold_cnt == LONG_T-1 -> emit LONG, hold_cnt <= 0, go LONG.
  - LONG: on tick hold_cnt++. When tick && hold_cnt == REPEAT_T-1 -> emit REPEAT and hold_cnt <= 0 (see BTN_REPEAT_EN).
  - Fall (!btn_st && btn_prev) in HELD or LONG -> emit RELEASE, go IDLE.
  - Fall and threshold in the same cycle: RELEASE only.
  - hold_cnt width is clog2(max(LONG_T, REPEAT_T)) and never wraps.
- Pending slot, one per button (flag + code):
  - Emit sets the flag and writes the code at the same edge.
  - If the flag is already set and the slot is not being granted at that edge: overwrite with the newer code and pulse ev_ovf for one cycle.
  - If it is being granted at that edge: the grant takes the old code, the slot takes the new code, and there is no ovf.
- Arbiter:
  - Output register is free when !ev_valid or (ev_valid && ev_ready).
  - When free, the lowest index >= rr_ptr (circular) with a pending flag is granted at the next edge. Its slot flag is cleared, ev_* are loaded, ev_valid = 1, and rr_ptr <= granted+1 mod N_BTN.
  - When free with nothing pending: ev_valid <= 0.
  - Throughput: one event per cycle.
  - ev_btn and ev_code hold stable while ev_valid && !ev_ready.
- Latency: a btn_st edge present before clock edge E0 is detected at E0 (slot written). ev_valid is high after E1 if the output register is free. Total 2 cycles.

Optional Feature:
- Macro BTN_REPEAT_EN.
- Defined: LONG state generates REPEAT every REPEAT_T ticks as described.
- Undefined:
  - LONG state only waits for release.
  - hold_cnt is frozen in LONG.
  - ev_code 3 is never produced.
  - The REPEAT_T parameter is accepted but unused.

Decomposition:
- Package btn_evt_pkg holds:
  - ev_code constants EV_PRESS=0, EV_RELEASE=1, EV_LONG=2, EV_REPEAT=3
  - FSM state encoding ST_IDLE, ST_HELD, ST_LONG
- Sub-module btn_fsm, instantiated N_BTN times, contains per-button edge detect, FSM, hold_cnt and pending slot.
  - Inputs: clk, rst_n, btn, tick, grant.
  - Outputs: pend, code, ovf.
- Top holds the prescaler, round-robin arbiter and output register.

Test Plan (N_BTN=4, TICK_DIV=4, LONG_T=3, REPEAT_T=2, BTN_REPEAT_EN defined, ev_ready=1 unless stated):
- btn_st[2] 0->1 at cycle 10, released at 12 -> ev_valid at cycle 12 with ev_btn=2, code=PRESS, then RELEASE; no LONG.
- btn_st[1] held 40 cycles -> PRESS; LONG 12 cycles (3 ticks) later; REPEAT every 8 cycles; RELEASE 2 cycles after fall.
- btn_st[0], [1] and [3] rise in the same cycle, rr_ptr=0 -> events emitted in order btn 0, 1, 3 on consecutive cycles. A repeat of the same test with rr_ptr=2 gives 3, 0, 1.
- ev_ready=0; btn_st[2] press then release while its slot is still pending -> one ev_ovf pulse; the remaining event for btn 2 is RELEASE; ev_* stable while stalled.
- rst_n asserted mid-LONG with btn_st[3]=1, released 5 cycles later -> all outputs 0 during reset; PRESS for btn 3 two cycles after release.
- Rebuild without BTN_REPEAT_EN, hold btn_st[0] for 60 cycles -> PRESS, LONG, then RELEASE only; ev_code never 3.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared event codes, per-button FSM state encoding and a small sizing helper
// for the button event controller.
package btn_evt_pkg;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_fsm.sv
// Per-button edge detect, press/hold classifier and single-entry pending slot.
// Auto-repeat in the LONG state is built only when BTN_REPEAT_EN is defined.
module btn_fsm #(
    parameter int unsigned LONG_T   = 500,
    parameter int unsigned REPEAT_T = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       tick,
    input  logic       grant,
    output logic       pend,
    output logic [1:0] code,
    output logic       ovf
);
    import btn_evt_pkg::*;

    localparam int unsigned CNT_W = $clog2(max_u(LONG_T, REPEAT_T));

    logic             btn_prev;
    btn_state_e       state;
    btn_state_e       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rise;
    logic             fall;
    logic             emit;
    logic [1:0]       emit_code;

    assign rise = btn & ~btn_prev;
    assign fall = ~btn & btn_prev;

    // Release takes priority over any hold threshold reached in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        emit      = 1'b0;
        emit_code = EV_PRESS;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    emit      = 1'b1;
                    emit_code = EV_PRESS;
                    cnt_nxt   = '0;
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    emit      = 1'b1;
                    emit_code = EV_RELEASE;
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    if (hold_cnt == CNT_W'(LONG_T - 1)) begin
                        emit      = 1'b1;
                        emit_code = EV_LONG;
                        cnt_nxt   = '0;
                        state_nxt = ST_LONG;
                    end else begin
                        cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            ST_LONG: begin
                if (fall) begin
                    emit      = 1'b1;
                    emit_code = EV_RELEASE;
                    state_nxt = ST_IDLE;
                end
`ifdef BTN_REPEAT_EN
                else if (tick) begin
                    if (hold_cnt == CNT_W'(REPEAT_T - 1)) begin
                        emit      = 1'b1;
                        emit_code = EV_REPEAT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A new event landing on an ungranted full slot replaces the older one.
    assign ovf = emit & pend & ~grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= 1'b0;
            state    <= ST_IDLE;
            hold_cnt <= '0;
            pend     <= 1'b0;
            code     <= EV_PRESS;
        end else begin
            btn_prev <= btn;
            state    <= state_nxt;
            hold_cnt <= cnt_nxt;
            if (emit) begin
                pend <= 1'b1;
                code <= emit_code;
            end else if (grant) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: shared tick prescaler, per-button classifiers and a
// round-robin arbiter onto one valid/ready event port. Option: BTN_REPEAT_EN.
module btn_event_ctrl #(
    parameter int unsigned N_BTN    = 4,
    parameter int unsigned TICK_DIV = 12000,
    parameter int unsigned LONG_T   = 500,
    parameter int unsigned REPEAT_T = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_st,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_btn,
    output logic [1:0]               ev_code,
    output logic                     ev_ovf
);
    import btn_evt_pkg::*;

    localparam int unsigned BTN_W = $clog2(N_BTN);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] presc;
    logic             tick_c;
    logic [BTN_W-1:0] rr_ptr;
    logic [N_BTN-1:0] pend_vec;
    logic [N_BTN-1:0] ovf_vec;
    logic [N_BTN-1:0] grant_vec;
    logic [1:0]       code_vec [N_BTN];
    logic             out_free_c;
    logic             found_c;
    logic [BTN_W-1:0] sel_c;
    int unsigned      idx;

    assign tick_c = (presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
        btn_fsm #(
            .LONG_T   (LONG_T),
            .REPEAT_T (REPEAT_T)
        ) u_fsm (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_st[i]),
            .tick  (tick_c),
            .grant (grant_vec[i]),
            .pend  (pend_vec[i]),
            .code  (code_vec[i]),
            .ovf   (ovf_vec[i])
        );
    end

    // Circular search for the first pending slot starting at rr_ptr.
    always_comb begin
        out_free_c = ~ev_valid | ev_ready;
        found_c    = 1'b0;
        sel_c      = '0;
        idx        = 0;
        grant_vec  = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!found_c && pend_vec[BTN_W'(idx)]) begin
                found_c = 1'b1;
                sel_c   = BTN_W'(idx);
            end
        end
        if (out_free_c && found_c) begin
            grant_vec[sel_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid <= 1'b0;
            ev_btn   <= '0;
            ev_code  <= EV_PRESS;
            ev_ovf   <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            ev_ovf <= |ovf_vec;
            if (out_free_c) begin
                if (found_c) begin
                    ev_valid <= 1'b1;
                    ev_btn   <= sel_c;
                    ev_code  <= code_vec[sel_c];
                    rr_ptr   <= (sel_c == BTN_W'(N_BTN - 1)) ? '0 : sel_c + BTN_W'(1);
                end else begin
                    ev_valid <= 1'b0;
                end
            end
        end
    end

endmodule
